sweep_ctrl: RTL
===============

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the phase-increment word driven to the sine generator.
REQ-002 Parameter DWELL_WIDTH, default 16: width of the dwell and hold cycle counts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate any sweep immediately.
REQ-007 incr_min  input  WIDTH  sweep lower bound.
REQ-008 incr_max  input  WIDTH  sweep upper bound.
REQ-009 step  input  WIDTH  increment change per dwell period.
REQ-010 dwell  input  DWELL_WIDTH  each incr value lasts dwell+1 cycles in UP and DOWN.
REQ-011 hold  input  DWELL_WIDTH  HOLD lasts hold+1 cycles.
REQ-012 en  output  1  enable to the sine generator's address counter.
REQ-013 incr  output  WIDTH  phase increment to the sine generator.
REQ-014 busy  output  1  high in UP, HOLD and DOWN.
REQ-015 done  output  1  one-cycle pulse on normal sweep completion.
REQ-016 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 FSM states SHALL be IDLE, UP, HOLD and DOWN; en and busy SHALL be 1 exactly when the state is not IDLE; all outputs SHALL be registered.
REQ-018 In IDLE, start=1 with incr_min<=incr_max SHALL latch incr_min, incr_max, step, dwell and hold (step=0 latched as 1), enter UP next cycle with incr=incr_min, and clear the dwell counter.
REQ-019 In IDLE, start=1 with incr_min>incr_max SHALL remain in IDLE and pulse err for one cycle in the next cycle.
REQ-020 Configuration input changes during a sweep SHALL have no effect; start outside IDLE SHALL be ignored.
REQ-021 The dwell counter SHALL count 0..dwell, expire at dwell, and restart at 0 on each state change and incr change.
REQ-022 UP, on dwell expiry: if incr==max, go to HOLD with incr unchanged; else incr <= min(incr+step, max), computed at WIDTH+1 bits (no wrap).
REQ-023 HOLD, after hold+1 cycles: enter DOWN with incr <= max(incr-step, min), computed without underflow.
REQ-024 DOWN, on dwell expiry: if incr==min, go to IDLE; else incr <= max(incr-step, min).
REQ-025 On the DOWN->IDLE transition, done SHALL be 1, and en, busy and incr SHALL be 0 in the same (first IDLE) cycle.
REQ-026 In IDLE, incr SHALL be 0 and done and err SHALL be 0 except for the single pulse cycles.
REQ-027 abort=1 in any state SHALL force IDLE next cycle with en=0, incr=0, busy=0 and no done; abort overrides a simultaneous start, and a simultaneous dwell expiry.
REQ-028 incr_min==incr_max SHALL produce UP for dwell+1 cycles, HOLD for hold+1 cycles, DOWN for dwell+1 cycles, then done.

Reset
REQ-029 rst=1 SHALL set state IDLE, en=0, incr=0, busy=0, done=0, err=0, clear the counters and latched configuration, and take priority over start and abort.
REQ-030 rst asserted mid-sweep SHALL abandon the sweep with no done pulse; the first start is accepted in the cycle after rst deasserts.

Structure
REQ-031 Package sweep_pkg SHALL hold the state enum typedef (IDLE, UP, HOLD, DOWN) and default width constants.
REQ-032 The dwell/hold cycle counter SHALL be one sub-module, dwell_timer (load, clear, expire output).
REQ-033 en and incr SHALL connect directly to the sine generator's en and incr ports without glue logic.

Verification
REQ-034 Case 1: start at cycle t with min=0, max=4, step=2, dwell=1, hold=2 -> incr 0,0,2,2,4,4,4,4,4,2,2,0,0 over t+1..t+13, with done=1 and incr=0 at t+14.
REQ-035 Case 2: min=250, max=255, step=10, dwell=0, hold=0 -> UP incr 250,255 then HOLD 255, DOWN 250, done; no wrap.
REQ-036 Case 3: abort during HOLD of case 1 -> next cycle en=0, incr=0, busy=0, done never pulses; a new start is accepted the cycle after.
REQ-037 Case 4: start with min=9, max=3 -> err pulse one cycle, busy stays 0; step=0 with min=0, max=2 -> incr steps 0,1,2.
REQ-038 Case 5: rst pulsed mid-UP -> all outputs 0 next cycle; start and abort held together in IDLE -> stays IDLE.
REQ-039 Case 6: config inputs changed every cycle during a sweep -> sequence identical to the case 1 run.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency-sweep controller.
//   sweep_state_t   : controller FSM states (IDLE, UP, HOLD, DOWN)
//   DEF_WIDTH       : default phase-increment width
//   DEF_DWELL_WIDTH : default dwell/hold count width
package sweep_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_DWELL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Cycle counter used for both the dwell period (UP/DOWN) and the hold period.
// The count runs 0..limit; expire is high while count equals the limit.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : capture limit as the new terminal count
//   limit    : terminal count value (period is limit+1 cycles)
//   clear    : restart the count at 0 on the next cycle
//   expire   : count has reached the terminal value
module dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] limit,
  input  logic         clear,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic [W-1:0] lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lim <= '0;
    end else begin
      if (load) lim <= limit;
      // The controller always clears on expiry, so the count never wraps
      // while a period is in progress.
      if (clear) cnt <= '0;
      else       cnt <= cnt + W'(1);
    end
  end

  assign expire = (cnt == lim);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller for a sine generator. Ramps the phase increment
// from incr_min up to incr_max in steps, holds at the top, ramps back down,
// then returns to IDLE with a one-cycle done pulse.
// Handshake: start is a level request sampled only in IDLE; an accepted start
// begins the sweep on the next cycle, a start with incr_min > incr_max is
// answered with a one-cycle err pulse. abort and rst end any sweep at once.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   start, abort        : sweep request / immediate termination
//   incr_min, incr_max  : sweep bounds (latched at start)
//   step                : increment change per dwell period (0 treated as 1)
//   dwell, hold         : per-value dwell length-1 and top hold length-1
//   en, incr            : straight to the sine generator's en / incr ports
//   busy, done, err     : status; done and err are one-cycle pulses
//   state               : current FSM state for observation
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       incr_min,
  input  logic [WIDTH-1:0]       incr_max,
  input  logic [WIDTH-1:0]       step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [DWELL_WIDTH-1:0] hold,
  output logic                   en,
  output logic [WIDTH-1:0]       incr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output sweep_state_t           state
);

  logic [WIDTH-1:0]       min_q, max_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q, hold_q;

  logic                   expire;
  logic                   tmr_clear;
  logic                   tmr_load;
  logic [DWELL_WIDTH-1:0] tmr_val;

  logic                   cfg_ok;
  logic [WIDTH:0]         up_sum;
  logic [WIDTH:0]         dn_diff;
  logic [WIDTH-1:0]       up_next;
  logic [WIDTH-1:0]       dn_next;

  assign cfg_ok = (incr_min <= incr_max);

  // Saturating ramp arithmetic carried at WIDTH+1 bits so neither direction
  // can wrap past the bounds.
  always_comb begin
    up_sum  = {1'b0, incr} + {1'b0, step_q};
    dn_diff = {1'b0, incr} - {1'b0, step_q};
    up_next = (up_sum > {1'b0, max_q}) ? max_q : up_sum[WIDTH-1:0];
    dn_next = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < min_q)) ? min_q
                                                               : dn_diff[WIDTH-1:0];
  end

  // Timer control: the count restarts whenever the state or incr changes,
  // which in every active state coincides with expiry. The terminal value is
  // swapped to hold on UP->HOLD and back to dwell on HOLD->DOWN.
  always_comb begin
    tmr_clear = 1'b1;
    tmr_load  = 1'b0;
    tmr_val   = dwell_q;
    if (!abort) begin
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            tmr_load = 1'b1;
            tmr_val  = dwell;
          end
        end
        UP: begin
          tmr_clear = expire;
          if (expire && (incr == max_q)) begin
            tmr_load = 1'b1;
            tmr_val  = hold_q;
          end
        end
        HOLD: begin
          tmr_clear = expire;
          if (expire) begin
            tmr_load = 1'b1;
            tmr_val  = dwell_q;
          end
        end
        DOWN: tmr_clear = expire;
        default: tmr_clear = 1'b1;
      endcase
    end
  end

  dwell_timer #(.W(DWELL_WIDTH)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .limit  (tmr_val),
    .clear  (tmr_clear),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      incr    <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      hold_q  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state <= IDLE;
        incr  <= '0;
        en    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            incr <= '0;
            if (start) begin
              if (cfg_ok) begin
                min_q   <= incr_min;
                max_q   <= incr_max;
                step_q  <= (step == '0) ? WIDTH'(1) : step;
                dwell_q <= dwell;
                hold_q  <= hold;
                incr    <= incr_min;
                en      <= 1'b1;
                busy    <= 1'b1;
                state   <= UP;
              end else begin
                err <= 1'b1;
              end
            end
          end
          UP: begin
            if (expire) begin
              if (incr == max_q) state <= HOLD;
              else               incr  <= up_next;
            end
          end
          HOLD: begin
            if (expire) begin
              state <= DOWN;
              incr  <= dn_next;
            end
          end
          DOWN: begin
            if (expire) begin
              if (incr == min_q) begin
                state <= IDLE;
                incr  <= '0;
                en    <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                incr <= dn_next;
              end
            end
          end
          default: begin
            state <= IDLE;
            incr  <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
